// File: rtl/note_sequencer.sv
// note_sequencer: looping step sequencer with record/overdub and a live-key
// arbiter feeding the single tone generator. All outputs are registered.
module note_sequencer #(
  parameter int unsigned CLK_FREQ = 12_000_000,
  parameter int unsigned STEP_HZ  = 8,
  parameter int unsigned STEPS    = 16,
  localparam int unsigned SW      = $clog2(STEPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    keys,
  input  logic          play,
  input  logic          rec,
  input  logic          clear,
  output logic [1:0]    note,
  output logic          gate,
  output logic          src_live,
  output logic [SW-1:0] step_idx,
  output logic          running
);

  localparam int unsigned STEP_TICKS = CLK_FREQ / STEP_HZ;
  localparam int unsigned TW         = $clog2(STEP_TICKS);
  localparam int unsigned GATE_END   = STEP_TICKS - STEP_TICKS / 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    REC  = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [TW-1:0]   tick;
  logic [STEPS-1:0] valid;
  logic [1:0]      mem_note [STEPS];
  logic [3:0]      keys_prev;

  logic            live;
  logic            rec_wr;
  logic            seq_run;
  logic            seq_gate;
  logic            tick_wrap;

  // Lowest set key wins.
  function automatic logic [1:0] pri(input logic [3:0] k);
    if (k[0])      pri = 2'd0;
    else if (k[1]) pri = 2'd1;
    else if (k[2]) pri = 2'd2;
    else           pri = 2'd3;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: play toggles run/stop and overrides rec.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (play) state_next = PLAY;
      PLAY: begin
        if (play)     state_next = IDLE;
        else if (rec) state_next = REC;
      end
      REC: begin
        if (play)      state_next = IDLE;
        else if (!rec) state_next = PLAY;
      end
      default: state_next = IDLE;
    endcase
  end

  // Combinational helpers for the datapath.
  // seq_run also requires state_next so a stop pulse silences the gate on the
  // very next cycle, and the first running cycle after start stays silent.
  always_comb begin
    live      = (keys != '0);
    rec_wr    = (state == REC) && live && (keys_prev == '0);
    seq_run   = (state != IDLE) && (state_next != IDLE);
    tick_wrap = (tick == TW'(STEP_TICKS - 1));
    seq_gate  = seq_run && valid[step_idx] && (tick < TW'(GATE_END));
  end

  // Tempo, valid bits, key history and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick      <= '0;
      step_idx  <= '0;
      valid     <= '0;
      keys_prev <= '0;
      note      <= '0;
      gate      <= 1'b0;
      src_live  <= 1'b0;
      running   <= 1'b0;
    end else begin
      keys_prev <= keys;
      running   <= (state_next != IDLE);

      if (state == IDLE && play) begin
        tick     <= '0;
        step_idx <= '0;
      end else if (seq_run) begin
        if (tick_wrap) begin
          tick     <= '0;
          step_idx <= step_idx + SW'(1);
        end else begin
          tick <= tick + TW'(1);
        end
      end

      if (clear)       valid           <= '0;
      else if (rec_wr) valid[step_idx] <= 1'b1;

      if (live) begin
        gate     <= 1'b1;
        note     <= pri(keys);
        src_live <= 1'b1;
      end else begin
        gate     <= seq_gate;
        src_live <= 1'b0;
        if (seq_gate) note <= mem_note[step_idx];
      end
    end
  end

  // Pattern note storage; validity is tracked separately so no reset needed.
  always_ff @(posedge clk) begin
    if (rec_wr) mem_note[step_idx] <= pri(keys);
  end

endmodule
